// File: rtl/sa_ram_rd_streamer.sv
// ---------------------------------------------------------------------------
// sa_ram_rd_streamer
// Read-side controller for the 64x18 two-port SA RAM. A command carries a
// start address and a word count. The block walks the RAM read port one
// address per cycle. It captures each read word one cycle after its enable
// and presents the words as a valid/ready stream. The final word of the
// command is flagged with out_last.
//
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   cmd_valid     command request (ignored unless cmd_ready)
//   cmd_ready     command accept, high only while idle and out of reset
//   cmd_addr      first RAM address of the command
//   cmd_len       number of words, 0..2**AW
//   ram_ra        registered RAM read address
//   ram_re        RAM read enable
//   ram_dout      RAM read data, valid the cycle after ram_re
//   out_valid     stream word valid
//   out_ready     sink ready
//   out_data      stream word (head of the skid FIFO)
//   out_last      head word is the last of the command
//   busy          a command is in progress
//   done          one-cycle pulse when a command completes
// ---------------------------------------------------------------------------
module sa_ram_rd_streamer #(
  parameter int AW = 6,
  parameter int DW = 18,
  parameter int LW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  localparam logic [LW-1:0] LEN_ONE  = LW'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_ra;
  logic [LW-1:0] r_remaining;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_beat;
  logic          r_inflight;
  logic          r_done;

  logic [DW-1:0] r_fifo [2];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_cnt;

  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_last_pop;
  logic [2:0]    w_credit;
  logic          w_re;

  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;

  assign out_valid  = (r_cnt != 2'd0);
  assign out_data   = r_fifo[r_rptr];
  assign out_last   = out_valid && (r_beat == r_len - LEN_ONE);
  assign w_pop      = out_valid && out_ready;
  assign w_push     = r_inflight;
  assign w_last_pop = w_pop && out_last;

  // Credit counts every word that will occupy the skid FIFO next cycle:
  // stored words plus the word returning from the RAM, less the one leaving.
  // Issuing only while this is below two means the FIFO can never overflow.
  assign w_credit = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_re     = (r_state == S_READ) && (r_remaining != '0) && (w_credit < 3'd2);

  assign ram_re = w_re;
  assign ram_ra = r_ra;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;

  // Next-state selection: leave READ on the issue of the final address and
  // leave DRAIN once the last word has been taken by the sink.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (cmd_len != '0)) w_next = S_READ;
      S_READ:  if (w_re && (r_remaining == LEN_ONE)) w_next = S_DRAIN;
      S_DRAIN: if (w_last_pop) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command bookkeeping: address walk, remaining count, popped-beat count
  // and the completion pulse. A zero-length command completes immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ra        <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_re;
      r_done     <= (w_accept && (cmd_len == '0)) ||
                    ((r_state == S_DRAIN) && w_last_pop);
      if (w_pop) r_beat <= r_beat + LEN_ONE;
      if (w_accept && (cmd_len != '0)) begin
        r_ra        <= cmd_addr;
        r_remaining <= cmd_len;
        r_len       <= cmd_len;
        r_beat      <= '0;
      end else if (w_re) begin
        r_ra        <= r_ra + ADDR_ONE;
        r_remaining <= r_remaining - LEN_ONE;
      end
    end
  end

  // Two-entry skid FIFO. It is written with the RAM word in the cycle after
  // each read enable and drained by the stream handshake. Push and pop may
  // happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= ram_dout;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // A push into a full FIFO without a matching pop would lose a word.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_cnt == 2'd2)));

endmodule
